// File: rtl/seq_alu.sv
// Multi-cycle ALU. Single-cycle ops finish in one clock. Multiply and divide
// iterate over operand magnitudes, then get a one-cycle sign fix before HI/LO are written.
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [4:0]       ALUOp,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] C,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

    localparam logic [4:0] OP_ADDU  = 5'd0,  OP_SUBU  = 5'd1,  OP_OR    = 5'd2;
    localparam logic [4:0] OP_AND   = 5'd3,  OP_LUI   = 5'd4,  OP_SLT   = 5'd5;
    localparam logic [4:0] OP_SLTU  = 5'd6,  OP_SLL   = 5'd7,  OP_SRL   = 5'd8;
    localparam logic [4:0] OP_SRA   = 5'd9,  OP_EQL   = 5'd10, OP_NE    = 5'd11;
    localparam logic [4:0] OP_MULT  = 5'd12, OP_MULTU = 5'd13, OP_DIV   = 5'd14;
    localparam logic [4:0] OP_DIVU  = 5'd15, OP_MFHI  = 5'd16, OP_MFLO  = 5'd17;
    localparam logic [SHW-1:0] LAST_ITER = SHW'(WIDTH - 1);

    state_t             state;
    logic [4:0]         op_r;
    logic [WIDTH-1:0]   a_r, b_r, hi, lo;
    logic [SHW-1:0]     cnt;
    logic [2*WIDTH-1:0] prod;

    logic [WIDTH-1:0]   simple_c, mag_a, mag_b, new_hi, new_lo;
    logic               simple_zero, signed_in, sign_a, sign_b, is_mult_r;
    logic [SHW-1:0]     shamt;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] mul_next, div_next, prod_neg;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    assign shamt     = A[SHW-1:0];
    assign signed_in = (ALUOp == OP_MULT) || (ALUOp == OP_DIV);
    assign sign_a    = ((op_r == OP_MULT) || (op_r == OP_DIV)) && a_r[WIDTH-1];
    assign sign_b    = ((op_r == OP_MULT) || (op_r == OP_DIV)) && b_r[WIDTH-1];
    assign is_mult_r = (op_r == OP_MULT) || (op_r == OP_MULTU);
    assign mag_a     = magnitude(a_r, sign_a);
    assign mag_b     = magnitude(b_r, sign_b);

    // Single-cycle results, computed straight from the inputs at acceptance
    always_comb begin
        simple_c = '0;
        case (ALUOp)
            OP_ADDU: simple_c = A + B;
            OP_SUBU: simple_c = A - B;
            OP_OR:   simple_c = A | B;
            OP_AND:  simple_c = A & B;
            OP_LUI:  simple_c = B << (WIDTH / 2);
            OP_SLT:  simple_c = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
            OP_SLTU: simple_c = {{(WIDTH-1){1'b0}}, A < B};
            OP_SLL:  simple_c = B << shamt;
            OP_SRL:  simple_c = B >> shamt;
            OP_SRA:  simple_c = $signed(B) >>> shamt;
            OP_MFHI: simple_c = hi;
            OP_MFLO: simple_c = lo;
            default: simple_c = '0;
        endcase
        if (ALUOp == OP_EQL)
            simple_zero = (A == B);
        else if (ALUOp == OP_NE)
            simple_zero = (A != B);
        else
            simple_zero = (simple_c == '0);
    end

    // prod holds {partial, multiplier} while multiplying and {remainder, dividend/quotient} while dividing
    always_comb begin
        mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, (prod[0] ? mag_a : '0)};
        mul_next  = {mul_sum, prod[WIDTH-1:1]};
        div_shift = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
        div_diff  = div_shift - {1'b0, mag_b};
        div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], prod[WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], prod[WIDTH-2:0], 1'b1};
    end

    // Sign correction applied in FIX; a zero divisor bypasses the datapath result
    always_comb begin
        prod_neg = -prod;
        new_hi   = '0;
        new_lo   = '0;
        if (is_mult_r) begin
            new_hi = (sign_a ^ sign_b) ? prod_neg[2*WIDTH-1:WIDTH] : prod[2*WIDTH-1:WIDTH];
            new_lo = (sign_a ^ sign_b) ? prod_neg[WIDTH-1:0] : prod[WIDTH-1:0];
        end else if (b_r == '0) begin
            new_hi = a_r;
            new_lo = '1;
        end else begin
            new_hi = sign_a ? -prod[2*WIDTH-1:WIDTH] : prod[2*WIDTH-1:WIDTH];
            new_lo = (sign_a ^ sign_b) ? -prod[WIDTH-1:0] : prod[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            op_r  <= '0;
            a_r   <= '0;
            b_r   <= '0;
            hi    <= '0;
            lo    <= '0;
            cnt   <= '0;
            prod  <= '0;
            C     <= '0;
            zero  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_r <= ALUOp;
                        a_r  <= A;
                        b_r  <= B;
                        cnt  <= '0;
                        busy <= 1'b1;
                        if ((ALUOp == OP_MULT) || (ALUOp == OP_MULTU)) begin
                            prod  <= {{WIDTH{1'b0}}, magnitude(B, signed_in && B[WIDTH-1])};
                            state <= MUL;
                        end else if ((ALUOp == OP_DIV) || (ALUOp == OP_DIVU)) begin
                            prod  <= {{WIDTH{1'b0}}, magnitude(A, signed_in && A[WIDTH-1])};
                            state <= DIV;
                        end else begin
                            C     <= simple_c;
                            zero  <= simple_zero;
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                MUL: begin
                    prod <= mul_next;
                    cnt  <= cnt + SHW'(1);
                    if (cnt == LAST_ITER)
                        state <= FIX;
                end
                DIV: begin
                    prod <= div_next;
                    cnt  <= cnt + SHW'(1);
                    if (cnt == LAST_ITER)
                        state <= FIX;
                end
                FIX: begin
                    hi    <= new_hi;
                    lo    <= new_lo;
                    C     <= new_lo;
                    zero  <= (new_lo == '0);
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
